spi_txn_sequencer: RTL and testbench
====================================

Name: spi_txn_sequencer

Overview:
- Transaction controller for the SPI link: sequences one 16-bit frame per request (byte 0 = {RW, addr[6:0]}, byte 1 = data), MSB first.
- Arbitrates two requesters round-robin onto the single SPI port.
- Generates SCLK (mode 0), CS and MOSI, and captures MISO for reads.
- Replaces the free-running SCLK and ad-hoc enables around the shift register/FSM pair with one clocked sequencer.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 2.
- ADDR_W, 7, address bits; frame bit 7 is RW.
- DATA_W, 8, data byte width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  2  per-requester transaction request, level, held until grant.
- rw  input  2  per-requester RW: 1 = read, 0 = write.
- addr0, addr1  input  7 each  target address.
- wdata0, wdata1  input  8 each  write data.
- grant  output  2  one-cycle pulse; the winner's rw/addr/wdata are latched in that cycle.
- done  output  2  one-cycle pulse at transaction end.
- rdata  output  8  last read byte; valid from the done pulse.
- busy  output  1  high from grant until return to IDLE.
- sclk  output  1  SPI clock; idle low.
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial out.
- miso  input  1  serial in; conditioned externally.

Behaviour:
- Reset (async, immediate): cs_n=1, sclk=0, mosi=0, busy=0, grant=0, done=0, rdata=0x00, state=IDLE, RR pointer favours requester 0.
- Reset mid-transaction aborts with no done pulse.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GUARD -> IDLE.
- IDLE, arbitration:
  - At edge T with any req high, pick the winner.
  - If both are high, pick the one not served last.
  - Assert grant[i] for cycle T..T+1 and latch the frame.
  - cs_n=0, busy=1, mosi = frame[15]. Go to SETUP.
- Frame contents:
  - Write: {0, addr, wdata}.
  - Read: {1, addr, 8'h00}; wdata is ignored.
- SETUP: hold for CLK_DIV cycles with sclk low, then go to SHIFT.
- SHIFT: 16 SCLK periods; each level lasts CLK_DIV cycles.
  - Rising edge: shift miso into rx[15:0].
  - Falling edge: advance bit counter; mosi = next frame bit.
  - After the 16th falling edge, go to HOLD.
- HOLD: CLK_DIV cycles with cs_n=0, sclk=0.
- GUARD entry (edge T+34*CLK_DIV):
  - cs_n=1, done[i] pulses for one cycle.
  - If read, rdata = rx[7:0] on the same edge; if write, rdata is unchanged.
- GUARD: CLK_DIV cycles with cs_n high (minimum deselect time); busy=0 on exit to IDLE.
- Requests:
  - Requests arriving during any non-IDLE state wait; none are lost or granted early.
  - A req still high after done is treated as a new request.
- Round robin: the pointer updates only on grant. Back-to-back requests from both requesters alternate 0,1,0,1.
- Width: bit counter 4 bits (0..15), no wrap within a frame; divider counter $clog2(CLK_DIV) bits, reloads on every terminal count.
- Simultaneous events:
  - Grant and reset in the same cycle: reset wins.
  - A req change while granted has no effect on the latched frame.

Decomposition:
- Package spi_seq_pkg:
  - state encoding (IDLE, SETUP, SHIFT, HOLD, GUARD)
  - FRAME_W=16
  - RW_BIT=7, RW_READ=1
  - default CLK_DIV
- One sub-module spi_sclk_divider(clk, rst_n, run, sclk, rise_tick, fall_tick):
  - divider and sclk toggle
  - single-cycle tick pulses coincident with sclk edges
- The sequencer FSM, arbiter, and shift/capture registers stay in the top.

Test Plan:
- Write: req0, rw=0, addr 0x15, wdata 0xA5, CLK_DIV=4 -> slave samples 0x15 then 0xA5 on sclk rises; cs_n low 136 cycles; done[0] at T+136; rdata stays 0x00.
- Read: req1, rw=1, addr 0x2A, slave model drives 0x3C in byte 1 -> MOSI bytes 0xAA, 0x00; done[1] pulses with rdata=0x3C.
- Contention: req0 and req1 both held high from reset release -> grants in order 0,1,0,1; each cs_n low window is separated by >= CLK_DIV high cycles.
- Late request: req1 asserted while requester 0's transaction is in SHIFT -> no grant[1] until after GUARD; then grant[1] occurs on the first IDLE cycle.
- Abort: rst_n low at the 7th sclk rise -> cs_n=1, sclk=0, busy=0 without waiting for clk; no done. After release, a re-request replays the full 16 bits from bit 15.
- Parameter: CLK_DIV=2 -> sclk period 4 clk cycles; done at T+68; data identical to the write case.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
// A frame is {RW, addr[6:0], data[7:0]}, shifted MSB first.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GUARD = 3'd4
  } state_t;

  localparam int   FRAME_W         = 16;
  localparam int   RW_BIT          = 7;
  localparam logic RW_READ         = 1'b1;
  localparam int   DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/spi_sclk_divider.sv
// SCLK generator: toggles sclk every CLK_DIV clk cycles while run is high.
// The tick outputs flag the clk edge on which sclk rises or falls.
module spi_sclk_divider #(
  parameter int CLK_DIV = spi_seq_pkg::DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          term;

  assign term      = run && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = term && !sclk;
  assign fall_tick = term && sclk;

  // Dropping run parks sclk low and rearms the count for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (term) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Round-robin arbitrated SPI master: one 16-bit mode-0 frame per grant,
// with setup, hold and minimum deselect (guard) time around each frame.
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        rw,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CW = $clog2(CLK_DIV);

  state_t              state, state_nxt;
  logic [CW-1:0]       wait_cnt;
  logic                wait_done;
  logic [3:0]          bit_cnt;
  logic [FRAME_W-1:0]  tx;
  logic [DATA_W-1:0]   rx;
  logic                owner;
  logic                last;
  logic                is_read;
  logic                win;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [FRAME_W-1:0]  frame_sel;
  logic                run;
  logic                rise_tick;
  logic                fall_tick;

  assign wait_done = (wait_cnt == CW'(CLK_DIV - 1));
  assign run       = (state == SHIFT);
  assign busy      = (state != IDLE);
  assign cs_n      = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
  assign mosi      = tx[FRAME_W-1];

  spi_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Winner selection: on contention the requester not served last wins.
  always_comb begin
    win       = 1'b0;
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (req == 2'b11) win = ~last;
    else              win = req[1];
    if (win) begin
      sel_rw    = rw[1];
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end else begin
      sel_rw    = rw[0];
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end
    frame_sel = {sel_rw, sel_addr, (sel_rw == RW_READ) ? {DATA_W{1'b0}} : sel_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req) state_nxt = SETUP;
      SETUP:   if (wait_done) state_nxt = SHIFT;
      SHIFT:   if (fall_tick && (bit_cnt == 4'(FRAME_W - 1))) state_nxt = HOLD;
      HOLD:    if (wait_done) state_nxt = GUARD;
      GUARD:   if (wait_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame latch, serial shift/capture and the grant/done pulses.
  // wait_cnt restarts on every state change so each timed state lasts CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      done     <= '0;
      rdata    <= '0;
      tx       <= '0;
      rx       <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      is_read  <= 1'b0;
    end else begin
      grant    <= '0;
      done     <= '0;
      wait_cnt <= (state_nxt != state) ? '0 : wait_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (|req) begin
            grant   <= win ? 2'b10 : 2'b01;
            owner   <= win;
            last    <= win;
            tx      <= frame_sel;
            rx      <= '0;
            bit_cnt <= '0;
            is_read <= (frame_sel[DATA_W+RW_BIT] == RW_READ);
          end
        end
        SHIFT: begin
          if (rise_tick) rx <= {rx[DATA_W-2:0], miso};
          if (fall_tick) begin
            if (bit_cnt == 4'(FRAME_W - 1)) begin
              tx <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= {tx[FRAME_W-2:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (wait_done) begin
            done <= owner ? 2'b10 : 2'b01;
            if (is_read) rdata <= rx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer: a CLK_DIV=4 instance with a mode-0
// slave model, plus a CLK_DIV=2 instance for the divider-parameter case.
module tb_spi_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0, rw = '0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [1:0] grant, done;
  logic [7:0] rdata;
  logic       busy, sclk, cs_n, mosi;
  logic       miso = 1'b0;

  logic [1:0] b_req = '0, b_rw = '0;
  logic [6:0] b_addr0 = '0, b_addr1 = '0;
  logic [7:0] b_wdata0 = '0, b_wdata1 = '0;
  logic [1:0] b_grant, b_done;
  logic [7:0] b_rdata;
  logic       b_busy, b_sclk, b_cs_n, b_mosi;
  logic       b_miso = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] sl_tx = '0;
  logic [15:0] sl_sr = '0;
  logic [15:0] sl_rx = '0;
  int          sl_cnt = 0;
  logic [15:0] b_sl_rx = '0;

  spi_txn_sequencer #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .grant(grant), .done(done), .rdata(rdata), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_txn_sequencer #(.CLK_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .rw(b_rw),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .grant(b_grant), .done(b_done), .rdata(b_rdata), .busy(b_busy),
    .sclk(b_sclk), .cs_n(b_cs_n), .mosi(b_mosi), .miso(b_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-0 slave: presents its first bit at CS fall, shifts on SCLK fall, samples on rise.
  always @(negedge cs_n) begin
    sl_cnt = 0;
    sl_rx  = '0;
    sl_sr  = sl_tx;
    miso   = sl_tx[15];
  end
  always @(posedge sclk) begin
    sl_rx  = {sl_rx[14:0], mosi};
    sl_cnt = sl_cnt + 1;
  end
  always @(negedge sclk) begin
    sl_sr = {sl_sr[14:0], 1'b0};
    miso  = sl_sr[15];
  end

  always @(negedge b_cs_n) b_sl_rx = '0;
  always @(posedge b_sclk) b_sl_rx = {b_sl_rx[14:0], b_mosi};

  task automatic run_txn(input bit drop, output logic [1:0] gnt, output logic [1:0] dn,
                         output int tg, output int td, output int cs_low,
                         output bit extra, output bit ok);
    bit seen;
    seen = 0; gnt = '0; dn = '0; tg = 0; td = 0; cs_low = 0; extra = 0; ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (grant != 2'b00) begin
        if (!seen) begin
          seen = 1; gnt = grant; tg = cyc;
          if (drop) req = req & ~grant;
        end else begin
          extra = 1;
        end
      end
      if (seen && cs_n == 1'b0) cs_low++;
      if (done != 2'b00) begin
        dn = done; td = cyc; ok = seen;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_timeout: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; b_req = '0;
    @(negedge clk);
    n_cmp++; if (cs_n !== 1'b1)  begin n_fail++; $display("[TB] FAIL reset_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (sclk !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_sclk: got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_mosi: got %b want 0", mosi); end
    n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
    n_cmp++; if (done !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 00", done); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 00", rdata); end
    n_cmp++; if (b_cs_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_b_cs_n: got %b want 1", b_cs_n); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [1:0] g, d; int tg, td, cl; bit ex, ok;
    rw = 2'b00; addr0 = 7'h15; wdata0 = 8'hA5; sl_tx = 16'h0000;
    req = 2'b01;
    run_txn(1'b1, g, d, tg, td, cl, ex, ok);
    n_cmp++; if (ok !== 1'b1)    begin n_fail++; $display("[TB] FAIL write_timeout: ok=%b want 1", ok); end
    n_cmp++; if (g !== 2'b01)    begin n_fail++; $display("[TB] FAIL write_grant: got %b want 01", g); end
    n_cmp++; if (d !== 2'b01)    begin n_fail++; $display("[TB] FAIL write_done: got %b want 01", d); end
    n_cmp++; if (td - tg !== 136) begin n_fail++; $display("[TB] FAIL write_latency: got %0d want 136", td - tg); end
    n_cmp++; if (cl !== 136)     begin n_fail++; $display("[TB] FAIL write_cs_low: got %0d want 136", cl); end
    n_cmp++; if (sl_rx !== 16'h15A5) begin n_fail++; $display("[TB] FAIL write_mosi: got %h want 15a5", sl_rx); end
    n_cmp++; if (sl_cnt !== 16)  begin n_fail++; $display("[TB] FAIL write_rises: got %0d want 16", sl_cnt); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL write_rdata: got %h want 00", rdata); end
    n_cmp++; if (busy !== 1'b1)  begin n_fail++; $display("[TB] FAIL write_guard_busy: got %b want 1", busy); end
    wait_idle();
  endtask

  task automatic test_read();
    logic [1:0] g, d; int tg, td, cl; bit ex, ok;
    rw = 2'b10; addr1 = 7'h2A; wdata1 = 8'hFF; sl_tx = 16'h003C;
    req = 2'b10;
    run_txn(1'b1, g, d, tg, td, cl, ex, ok);
    n_cmp++; if (ok !== 1'b1)    begin n_fail++; $display("[TB] FAIL read_timeout: ok=%b want 1", ok); end
    n_cmp++; if (g !== 2'b10)    begin n_fail++; $display("[TB] FAIL read_grant: got %b want 10", g); end
    n_cmp++; if (d !== 2'b10)    begin n_fail++; $display("[TB] FAIL read_done: got %b want 10", d); end
    n_cmp++; if (sl_rx !== 16'hAA00) begin n_fail++; $display("[TB] FAIL read_mosi: got %h want aa00", sl_rx); end
    n_cmp++; if (rdata !== 8'h3C) begin n_fail++; $display("[TB] FAIL read_rdata: got %h want 3c", rdata); end
    sl_tx = 16'h0000;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] g, d; int tg, td, cl, td_prev; bit ex, ok;
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_f [4] = '{16'h1122, 16'h3344, 16'h1122, 16'h3344};
    rst_n = 1'b0;
    rw = 2'b00; addr0 = 7'h11; wdata0 = 8'h22; addr1 = 7'h33; wdata1 = 8'h44;
    req = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    td_prev = 0;
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b0, g, d, tg, td, cl, ex, ok);
      if (k == 3) req = 2'b00;
      n_cmp++; if (ok !== 1'b1)     begin n_fail++; $display("[TB] FAIL rr_timeout[%0d]: ok=%b want 1", k, ok); end
      n_cmp++; if (g !== exp_g[k])  begin n_fail++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", k, g, exp_g[k]); end
      n_cmp++; if (sl_rx !== exp_f[k]) begin n_fail++; $display("[TB] FAIL rr_frame[%0d]: got %h want %h", k, sl_rx, exp_f[k]); end
      if (k > 0) begin
        n_cmp++; if (tg - td_prev !== 5) begin n_fail++; $display("[TB] FAIL rr_deselect[%0d]: got %0d want 5", k, tg - td_prev); end
      end
      td_prev = td;
    end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL rr_rdata: got %h want 00", rdata); end
    wait_idle();
  endtask

  task automatic test_late_request();
    logic [1:0] g, d; int tg, td, cl, td0; bit ex, ok;
    rw = 2'b00; addr0 = 7'h15; wdata0 = 8'hA5; addr1 = 7'h33; wdata1 = 8'h44;
    req = 2'b01;
    fork
      run_txn(1'b1, g, d, tg, td, cl, ex, ok);
      begin repeat (20) @(negedge clk); req[1] = 1'b1; end
    join
    n_cmp++; if (ok !== 1'b1)  begin n_fail++; $display("[TB] FAIL late_timeout0: ok=%b want 1", ok); end
    n_cmp++; if (g !== 2'b01)  begin n_fail++; $display("[TB] FAIL late_grant0: got %b want 01", g); end
    n_cmp++; if (ex !== 1'b0)  begin n_fail++; $display("[TB] FAIL late_early_grant: got %b want 0", ex); end
    td0 = td;
    run_txn(1'b1, g, d, tg, td, cl, ex, ok);
    n_cmp++; if (ok !== 1'b1)  begin n_fail++; $display("[TB] FAIL late_timeout1: ok=%b want 1", ok); end
    n_cmp++; if (g !== 2'b10)  begin n_fail++; $display("[TB] FAIL late_grant1: got %b want 10", g); end
    n_cmp++; if (tg - td0 !== 5) begin n_fail++; $display("[TB] FAIL late_grant_time: got %0d want 5", tg - td0); end
    n_cmp++; if (sl_rx !== 16'h3344) begin n_fail++; $display("[TB] FAIL late_frame1: got %h want 3344", sl_rx); end
    wait_idle();
  endtask

  task automatic test_abort();
    logic [1:0] g, d; int tg, td, cl, rises; bit ex, ok, prev;
    rw = 2'b00; addr0 = 7'h15; wdata0 = 8'hA5;
    req = 2'b01;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (grant[0]) req = 2'b00;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 7) break;
    end
    n_cmp++; if (rises !== 7) begin n_fail++; $display("[TB] FAIL abort_reach: rises=%0d want 7", rises); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cs_n !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (sclk !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_sclk: got %b want 0", sclk); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (mosi !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_mosi: got %b want 0", mosi); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (done !== 2'b00) begin n_fail++; $display("[TB] FAIL abort_no_done: got %b want 00", done); end
    n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("[TB] FAIL abort_idle: got %b want 0", busy); end
    req = 2'b01;
    run_txn(1'b1, g, d, tg, td, cl, ex, ok);
    n_cmp++; if (ok !== 1'b1)     begin n_fail++; $display("[TB] FAIL replay_timeout: ok=%b want 1", ok); end
    n_cmp++; if (sl_rx !== 16'h15A5) begin n_fail++; $display("[TB] FAIL replay_frame: got %h want 15a5", sl_rx); end
    n_cmp++; if (sl_cnt !== 16)   begin n_fail++; $display("[TB] FAIL replay_rises: got %0d want 16", sl_cnt); end
    n_cmp++; if (td - tg !== 136) begin n_fail++; $display("[TB] FAIL replay_latency: got %0d want 136", td - tg); end
    wait_idle();
  endtask

  task automatic test_clk_div2();
    int tg, td, r1, r2, rises; bit seen, ok, prev;
    logic [1:0] dn;
    b_rw = 2'b00; b_addr0 = 7'h15; b_wdata0 = 8'hA5;
    b_req = 2'b01;
    tg = 0; td = 0; r1 = 0; r2 = 0; rises = 0; seen = 0; ok = 0; prev = 1'b0; dn = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (b_grant != 2'b00 && !seen) begin seen = 1; tg = cyc; b_req = 2'b00; end
      if (b_sclk && !prev) begin
        rises++;
        if (rises == 1) r1 = cyc;
        if (rises == 2) r2 = cyc;
      end
      prev = b_sclk;
      if (b_done != 2'b00) begin dn = b_done; td = cyc; ok = seen; break; end
    end
    n_cmp++; if (ok !== 1'b1)      begin n_fail++; $display("[TB] FAIL div2_timeout: ok=%b want 1", ok); end
    n_cmp++; if (dn !== 2'b01)     begin n_fail++; $display("[TB] FAIL div2_done: got %b want 01", dn); end
    n_cmp++; if (td - tg !== 68)   begin n_fail++; $display("[TB] FAIL div2_latency: got %0d want 68", td - tg); end
    n_cmp++; if (r2 - r1 !== 4)    begin n_fail++; $display("[TB] FAIL div2_sclk_period: got %0d want 4", r2 - r1); end
    n_cmp++; if (b_sl_rx !== 16'h15A5) begin n_fail++; $display("[TB] FAIL div2_frame: got %h want 15a5", b_sl_rx); end
    n_cmp++; if (b_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL div2_rdata: got %h want 00", b_rdata); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_late_request();
    test_abort();
    test_clk_div2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
